// File: rtl/mdct_recursion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdct_recursion_ctrl                                          |
// | Description : Frame controller for an external two-register MDCT           |
// |               recursion datapath. It latches the frame coefficient and     |
// |               initial state, loads them into the datapath, feeds           |
// |               FRAME_LEN samples and returns the final datapath output.     |
// |               Shadow copies of the datapath registers let the datapath     |
// |               reload its own state on bubble cycles.                       |
// | Ports       : clk_in/rst_sys   - clock, synchronous active-low reset       |
// |               start            - frame request (honoured in IDLE only)     |
// |               coef_in, init_*  - Q14 coefficient and initial state         |
// |               s_valid/s_ready/s_data - sample stream in                    |
// |               m_valid/m_ready/m_data - frame result out                    |
// |               busy             - controller not idle                       |
// |               sb_*             - datapath control/data, sb_out is its      |
// |                                  combinational output                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mdct_recursion_ctrl #(
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic               clk_in,
  input  logic               rst_sys,
  input  logic               start,
  input  logic signed [15:0] coef_in,
  input  logic signed [31:0] init_w3,
  input  logic signed [31:0] init_w6,
  input  logic               s_valid,
  input  logic signed [31:0] s_data,
  output logic               s_ready,
  output logic               m_valid,
  output logic signed [31:0] m_data,
  input  logic               m_ready,
  output logic               busy,
  output logic signed [31:0] sb_in,
  output logic               sb_rst_ctrl,
  output logic [31:0]        sb_w3,
  output logic [31:0]        sb_w6,
  output logic [15:0]        sb_t1,
  input  logic signed [31:0] sb_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Count value of the final sample of a frame.
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic signed [15:0] r_coef;
  logic signed [31:0] r_init_w3;
  logic signed [31:0] r_init_w6;
  logic signed [31:0] r_w4s;
  logic signed [31:0] r_w7s;
  logic signed [31:0] r_m_data;
  logic               r_m_valid;

  logic               w_accept;

  // Outputs are forced to their idle values while reset is held, so a frame
  // interrupted by reset cannot accept a sample on the reset edge.
  assign w_accept = rst_sys && (r_state == S_RUN) && s_valid;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;

  always_comb begin
    s_ready     = rst_sys && (r_state == S_RUN);
    busy        = rst_sys && (r_state != S_IDLE);
    sb_t1       = rst_sys ? r_coef : 16'd0;
    sb_rst_ctrl = 1'b1;
    sb_in       = '0;
    sb_w3       = r_w4s;
    sb_w6       = r_w7s;
    if (!rst_sys) begin
      sb_w3 = '0;
      sb_w6 = '0;
    end else if (r_state == S_LOAD) begin
      sb_w3 = r_init_w3;
      sb_w6 = r_init_w6;
    end else if (w_accept) begin
      sb_rst_ctrl = 1'b0;
      sb_in       = s_data;
    end
  end

  // Shadow of the datapath registers: reload value on hold/load cycles,
  // follow the recursion (out -> first, first -> second) on accept cycles.
  always_ff @(posedge clk_in) begin
    if (!rst_sys) begin
      r_w4s <= '0;
      r_w7s <= '0;
    end else if (sb_rst_ctrl) begin
      r_w4s <= sb_w3;
      r_w7s <= sb_w6;
    end else begin
      r_w4s <= sb_out;
      r_w7s <= r_w4s;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_sys) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_coef    <= '0;
      r_init_w3 <= '0;
      r_init_w6 <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_coef    <= coef_in;
            r_init_w3 <= init_w3;
            r_init_w6 <= init_w6;
            r_count   <= '0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_accept) begin
            if (r_count == C_LAST_IDX) begin
              r_m_data  <= sb_out;
              r_m_valid <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mdct_recursion_ctrl.md
MDCT_RECURSION_CTRL -- requirements
Module: mdct_recursion_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256: samples per frame, legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default 16: sample counter width; must satisfy 2^CNT_W > FRAME_LEN.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_sys, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: frame-start request, sampled only in IDLE.
REQ-006 SHALL have port coef_in, input, 16 bits signed: recursion coefficient, Q14.
REQ-007 SHALL have port init_w3, input, 32 bits signed: initial state loaded into the first recursion register.
REQ-008 SHALL have port init_w6, input, 32 bits signed: initial state loaded into the second recursion register.
REQ-009 SHALL have port s_valid, input, 1 bit: sample valid.
REQ-010 SHALL have port s_data, input, 32 bits signed: sample.
REQ-011 SHALL have port s_ready, output, 1 bit: sample accept.
REQ-012 SHALL have port m_valid, output, 1 bit: result valid.
REQ-013 SHALL have port m_data, output, 32 bits signed: frame result.
REQ-014 SHALL have port m_ready, input, 1 bit: result accept.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port sb_in, output, 32 bits signed: recursion datapath input.
REQ-017 SHALL have port sb_rst_ctrl, output, 1 bit: datapath state-load select.
REQ-018 SHALL have port sb_w3, output, 32 bits: datapath first-register load value.
REQ-019 SHALL have port sb_w6, output, 32 bits: datapath second-register load value.
REQ-020 SHALL have port sb_t1, output, 16 bits: datapath coefficient.
REQ-021 SHALL have port sb_out, input, 32 bits signed: datapath combinational output.

Function
REQ-022 SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-023 SHALL, in IDLE with start=1, latch coef_in, init_w3 and init_w6, clear the sample count and go to LOAD; start in any other state SHALL be ignored.
REQ-024 SHALL, in LOAD (exactly 1 cycle), drive sb_rst_ctrl=1, sb_w3=latched init_w3 and sb_w6=latched init_w6, then go to RUN.
REQ-025 SHALL drive s_ready=1 only in RUN; a sample is accepted when s_ready=1 and s_valid=1.
REQ-026 SHALL, on an accept cycle, drive sb_rst_ctrl=0 and sb_in=s_data, and increment the sample count.
REQ-027 SHALL, in every non-accept cycle other than LOAD, drive sb_rst_ctrl=1, sb_in=0, sb_w3=w4s and sb_w6=w7s, so that datapath state holds across bubbles.
REQ-028 SHALL maintain shadow registers w4s and w7s, updated every cycle as follows: if sb_rst_ctrl=1, w4s<=sb_w3 and w7s<=sb_w6; otherwise w4s<=sb_out and w7s<=w4s.
REQ-029 SHALL drive sb_t1 from the latched coefficient in all states.
REQ-030 SHALL, on the FRAME_LEN-th accept, capture sb_out into m_data and go to DONE the next cycle with m_valid=1.
REQ-031 SHALL hold m_valid=1 and m_data stable in DONE until m_ready=1, then go to IDLE with m_valid=0 the next cycle.
REQ-032 SHALL have a start-to-first-s_ready latency of 2 cycles, and a last-accept-to-m_valid latency of 1 cycle.
REQ-033 SHALL, for FRAME_LEN=1, enter DONE after a single accept.
REQ-034 SHALL perform no arithmetic of its own; w4s, w7s and m_data SHALL be plain 32-bit copies without saturation.

Reset
REQ-035 SHALL, while rst_sys=0 at a clk_in edge, force state=IDLE; count, w4s, w7s, the coefficient and init latches, and m_data to 0; and m_valid=0.
REQ-036 SHALL make combinational outputs in reset/IDLE equal s_ready=0, busy=0, sb_rst_ctrl=1, sb_in=0, sb_w3=0, sb_w6=0 and sb_t1=0.
REQ-037 SHALL, on reset asserted mid-frame (LOAD, RUN or DONE), abandon the frame and produce no m_valid for it.

Verification
REQ-038 SHALL be checked with FRAME_LEN=4, coef=0, init 0/0 and samples 1,2,3,4 back-to-back: expect m_data=2 one cycle after the 4th accept.
REQ-039 SHALL be checked with FRAME_LEN=4, coef=16384, init 0/0 and samples 1,0,0,0: expect m_data=-1 (0xFFFFFFFF).
REQ-040 SHALL be checked with FRAME_LEN=4, coef=0, init_w3=5, init_w6=3 and samples 0,0,0,0: expect m_data=5.
REQ-041 SHALL be checked with the REQ-038 stimulus plus 1-3 cycle s_valid gaps between samples: expect m_data=2, with sb_rst_ctrl=1 during every gap.
REQ-042 SHALL be checked with m_ready=0 for 5 cycles in DONE while start pulses: expect m_valid held, m_data unchanged and no restart; then m_ready=1 leads to IDLE and busy=0.
REQ-043 SHALL be checked with rst_sys=0 after the 2nd accept, then a new frame using the REQ-038 stimulus: expect m_valid=0 during reset and m_data=2 for the new frame.
